reg_write_arbiter: RTL and testbench

Shares the single register-file write port (A3/WD3/WE3) between two producers: the pipeline writeback stage and the cache controller's load-return path. Pipeline writes have priority. Load returns are buffered in a small FIFO, and an anti-starvation counter bounds how long they can wait. A pending-write mask is exported so the hazard unit can stall readers of registers with queued load returns.

---
 rtl/reg_write_arbiter.sv | 159 +++++++++++++++
 tb/tb_reg_write_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, load returns queue in a FIFO
// with a bounded-starvation force grant. Optional stats counters under REG_WRITE_ARB_STATS_EN.
module reg_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_valid,
  output logic                       pipe_ready,
  input  logic [4:0]                 pipe_addr,
  input  logic [31:0]                pipe_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [4:0]                 mem_addr,
  input  logic [31:0]                mem_data,
  output logic                       rf_we,
  output logic [4:0]                 rf_addr,
  output logic [31:0]                rf_wdata,
  output logic [31:0]                mem_pend_mask,
  output logic [$clog2(DEPTH):0]     fifo_count
`ifdef REG_WRITE_ARB_STATS_EN
  ,
  output logic [31:0]                conflict_cnt,
  output logic [31:0]                force_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_MEM
  } gnt_e;

  logic [4:0]       fifo_addr [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt;

  logic        count_nz;
  logic        force_head;
  logic        push;
  logic        pop;
  gnt_e        gnt;
  logic [4:0]  gnt_addr;
  logic [31:0] gnt_data;
  logic [31:0] pend;

  assign count_nz   = (count != '0);
  assign force_head = count_nz && (starve_cnt == STARVE_MAX);
  assign pipe_ready = rst && !force_head;
  assign mem_ready  = rst && (count != FULL_COUNT);
  assign push       = mem_valid && mem_ready;
  assign pop        = (gnt == GNT_MEM);
  assign fifo_count = count;

  always_comb begin
    gnt      = GNT_NONE;
    gnt_addr = '0;
    gnt_data = '0;
    if (pipe_valid && pipe_ready) begin
      gnt      = GNT_PIPE;
      gnt_addr = pipe_addr;
      gnt_data = pipe_data;
    end else if (count_nz) begin
      gnt      = GNT_MEM;
      gnt_addr = fifo_addr[rd_ptr];
      gnt_data = fifo_data[rd_ptr];
    end
  end

  // Storage carries no reset; validity is tracked separately in vld.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mem_addr;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!count_nz || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Writes to x0 are still granted and consumed; only the enable is suppressed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
    end else if (gnt != GNT_NONE) begin
      rf_we    <= (gnt_addr != 5'd0);
      rf_addr  <= gnt_addr;
      rf_wdata <= gnt_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld[i]) pend[fifo_addr[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign mem_pend_mask = pend;

`ifdef REG_WRITE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      conflict_cnt <= '0;
      force_cnt    <= '0;
    end else begin
      if (pipe_valid && count_nz) conflict_cnt <= conflict_cnt + 32'd1;
      if (force_head)             force_cnt    <= force_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed, table-driven bench for reg_write_arbiter (DEPTH=4, STARVE_LIMIT=3), plus
// hand-written starvation and FIFO-full sequences.
module tb_reg_write_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_valid;
  logic        pipe_ready;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [31:0] mem_pend_mask;
  logic [2:0]  fifo_count;
`ifdef REG_WRITE_ARB_STATS_EN
  logic [31:0] conflict_cnt;
  logic [31:0] force_cnt;
`endif

  reg_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_valid    (pipe_valid),
    .pipe_ready    (pipe_ready),
    .pipe_addr     (pipe_addr),
    .pipe_data     (pipe_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .rf_we         (rf_we),
    .rf_addr       (rf_addr),
    .rf_wdata      (rf_wdata),
    .mem_pend_mask (mem_pend_mask),
    .fifo_count    (fifo_count)
`ifdef REG_WRITE_ARB_STATS_EN
    ,
    .conflict_cnt  (conflict_cnt),
    .force_cnt     (force_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        pr;
    logic        mr;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] mask;
    logic [2:0]  cnt;
    logic        ck_reg;
    logic        ck_ad;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t vq[$];
  wr_t  log_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md,
                              input logic pr, input logic mr, input logic we, input logic [4:0] addr,
                              input logic [31:0] wdata, input logic [31:0] mask, input logic [2:0] cnt,
                              input logic ck_reg, input logic ck_ad);
    vec_t v;
    v.rst = r;  v.pv = pv; v.pa = pa; v.pd = pd; v.mv = mv; v.ma = ma; v.md = md;
    v.pr = pr;  v.mr = mr; v.we = we; v.addr = addr; v.wdata = wdata; v.mask = mask;
    v.cnt = cnt; v.ck_reg = ck_reg; v.ck_ad = ck_ad;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then sample mid-cycle.
  task automatic cyc(input logic r, input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                     input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wr_t w;
    @(negedge clk);
    rst = r; pipe_valid = pv; pipe_addr = pa; pipe_data = pd;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    #1;
    if (rf_we === 1'b1) begin
      w.a = rf_addr;
      w.d = rf_wdata;
      log_q.push_back(w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; pipe_valid = 1'b0; pipe_addr = '0; pipe_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;

    //          rst pv pa  pd            mv ma md             pr mr we addr wdata         mask          cnt ckr cka
    vq.push_back(mk(0, 1, 3, 32'h11,        1, 9, 32'h22,        0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0));
    vq.push_back(mk(0, 1, 3, 32'h11,        1, 9, 32'h22,        0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 1));
    vq.push_back(mk(1, 1, 5, 32'hDEADBEEF,  0, 0, 32'h0,         1, 1, 0, 0, 32'h0,        32'h0,        0, 1, 1));
    vq.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 1, 5, 32'hDEADBEEF, 32'h0,        0, 1, 1));
    vq.push_back(mk(1, 0, 0, 32'h0,         1, 7, 32'h12345678,  1, 1, 0, 5, 32'hDEADBEEF, 32'h0,        0, 1, 1));
    vq.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 0, 5, 32'hDEADBEEF, 32'h80,       1, 1, 1));
    vq.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 1, 7, 32'h12345678, 32'h0,        0, 1, 1));
    vq.push_back(mk(1, 1, 0, 32'hFFFFFFFF,  0, 0, 32'h0,         1, 1, 0, 7, 32'h12345678, 32'h0,        0, 1, 1));
    vq.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'hAAAA5555,  1, 1, 0, 0, 32'hFFFFFFFF, 32'h0,        0, 1, 1));
    vq.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 0, 0, 32'hFFFFFFFF, 32'h0,        1, 1, 1));
    vq.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 0, 0, 32'hAAAA5555, 32'h0,        0, 1, 1));
    vq.push_back(mk(1, 1, 1, 32'h1,         1, 2, 32'h2,         1, 1, 0, 0, 32'hAAAA5555, 32'h0,        0, 1, 1));
    vq.push_back(mk(1, 1, 3, 32'h3,         0, 0, 32'h0,         1, 1, 1, 1, 32'h1,        32'h4,        1, 1, 1));
    vq.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 1, 3, 32'h3,        32'h4,        1, 1, 1));
    vq.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 1, 2, 32'h2,        32'h0,        0, 1, 1));
    vq.push_back(mk(1, 0, 0, 32'h0,         1, 4, 32'h4,         1, 1, 0, 2, 32'h2,        32'h0,        0, 1, 1));
    vq.push_back(mk(1, 1, 8, 32'h8,         1, 6, 32'h6,         1, 1, 0, 2, 32'h2,        32'h10,       1, 1, 1));
    vq.push_back(mk(0, 1, 8, 32'h8,         1, 6, 32'h6,         0, 0, 1, 8, 32'h8,        32'h50,       2, 1, 1));
    vq.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 0, 0, 32'h0,        32'h0,        0, 1, 1));

    foreach (vq[i]) begin
      cyc(vq[i].rst, vq[i].pv, vq[i].pa, vq[i].pd, vq[i].mv, vq[i].ma, vq[i].md);
      chk($sformatf("v%0d pipe_ready", i), {31'b0, pipe_ready}, {31'b0, vq[i].pr});
      chk($sformatf("v%0d mem_ready", i),  {31'b0, mem_ready},  {31'b0, vq[i].mr});
      if (vq[i].ck_reg) begin
        chk($sformatf("v%0d rf_we", i),         {31'b0, rf_we},      {31'b0, vq[i].we});
        chk($sformatf("v%0d fifo_count", i),    {29'b0, fifo_count}, {29'b0, vq[i].cnt});
        chk($sformatf("v%0d mem_pend_mask", i), mem_pend_mask,       vq[i].mask);
      end
      if (vq[i].ck_ad) begin
        chk($sformatf("v%0d rf_addr", i),  {27'b0, rf_addr}, {27'b0, vq[i].addr});
        chk($sformatf("v%0d rf_wdata", i), rf_wdata,         vq[i].wdata);
      end
    end

    // Starvation: one queued load return, pipe held valid.
    cyc(1, 1, 10, 32'hA0, 1, 11, 32'hB0);
    chk("st0 pipe_ready", {31'b0, pipe_ready}, 32'd1);
    cyc(1, 1, 10, 32'hA0, 0, 0, 32'h0);
    chk("st1 pipe_ready", {31'b0, pipe_ready}, 32'd1);
    chk("st1 fifo_count", {29'b0, fifo_count}, 32'd1);
    cyc(1, 1, 10, 32'hA0, 0, 0, 32'h0);
    chk("st2 pipe_ready", {31'b0, pipe_ready}, 32'd1);
    cyc(1, 1, 10, 32'hA0, 0, 0, 32'h0);
    chk("st3 pipe_ready", {31'b0, pipe_ready}, 32'd1);
    cyc(1, 1, 10, 32'hA0, 0, 0, 32'h0);
    chk("st4 pipe_ready", {31'b0, pipe_ready}, 32'd0);
    chk("st4 rf_addr",    {27'b0, rf_addr},    32'd10);
    cyc(1, 1, 10, 32'hA0, 0, 0, 32'h0);
    chk("st5 pipe_ready", {31'b0, pipe_ready}, 32'd1);
    chk("st5 rf_we",      {31'b0, rf_we},      32'd1);
    chk("st5 rf_addr",    {27'b0, rf_addr},    32'd11);
    chk("st5 rf_wdata",   rf_wdata,            32'hB0);
    chk("st5 fifo_count", {29'b0, fifo_count}, 32'd0);
    cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);
    chk("st6 rf_addr",    {27'b0, rf_addr},    32'd10);

    // FIFO full: five back-to-back load returns while the pipe stays busy.
    log_q.delete();
    cyc(1, 1, 12, 32'hC0, 1, 13, 32'hD0);
    chk("ff0 mem_ready",  {31'b0, mem_ready},  32'd1);
    chk("ff0 fifo_count", {29'b0, fifo_count}, 32'd0);
    cyc(1, 1, 12, 32'hC0, 1, 14, 32'hD1);
    chk("ff1 fifo_count", {29'b0, fifo_count}, 32'd1);
    cyc(1, 1, 12, 32'hC0, 1, 15, 32'hD2);
    chk("ff2 fifo_count", {29'b0, fifo_count}, 32'd2);
    cyc(1, 1, 12, 32'hC0, 1, 16, 32'hD3);
    chk("ff3 fifo_count", {29'b0, fifo_count}, 32'd3);
    chk("ff3 pipe_ready", {31'b0, pipe_ready}, 32'd1);
    cyc(1, 1, 12, 32'hC0, 1, 17, 32'hD4);
    chk("ff4 fifo_count", {29'b0, fifo_count}, 32'd4);
    chk("ff4 mem_ready",  {31'b0, mem_ready},  32'd0);
    chk("ff4 pipe_ready", {31'b0, pipe_ready}, 32'd0);
    chk("ff4 mem_pend_mask", mem_pend_mask,    32'h0001E000);
    cyc(1, 1, 12, 32'hC0, 1, 17, 32'hD4);
    chk("ff5 fifo_count", {29'b0, fifo_count}, 32'd3);
    chk("ff5 mem_ready",  {31'b0, mem_ready},  32'd1);
    chk("ff5 rf_addr",    {27'b0, rf_addr},    32'd13);
    cyc(1, 1, 12, 32'hC0, 0, 0, 32'h0);
    chk("ff6 fifo_count", {29'b0, fifo_count}, 32'd4);
    chk("ff6 mem_ready",  {31'b0, mem_ready},  32'd0);
    cyc(1, 1, 12, 32'hC0, 0, 0, 32'h0);
    chk("ff7 pipe_ready", {31'b0, pipe_ready}, 32'd1);
    cyc(1, 1, 12, 32'hC0, 0, 0, 32'h0);
    chk("ff8 pipe_ready", {31'b0, pipe_ready}, 32'd0);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);
    chk("ff fifo_count drained", {29'b0, fifo_count}, 32'd0);

    n = 0;
    foreach (log_q[k]) begin
      if (log_q[k].a != 5'd12) begin
        chk($sformatf("ff order addr %0d", n), {27'b0, log_q[k].a}, 32'd13 + n);
        chk($sformatf("ff order data %0d", n), log_q[k].d, 32'hD0 + n);
        n++;
      end
    end
    chk("ff mem write count", n, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
